// File: rtl/ram_cmd_sequencer_if.sv
// Command, RAM and response signals of the RAM command sequencer.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface ram_cmd_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wr_enbl;
  logic                  rd_enbl;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_err;
  logic                  cmd_done;
  logic                  done_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, rd_data, rsp_ready,
    output cmd_ready, wr_enbl, rd_enbl, wr_addr, rd_addr, wr_data,
    output rsp_valid, rsp_data, rsp_addr, rsp_err, cmd_done, done_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, rd_data, rsp_ready,
    input  cmd_ready, wr_enbl, rd_enbl, wr_addr, rd_addr, wr_data,
    input  rsp_valid, rsp_data, rsp_addr, rsp_err, cmd_done, done_err
  );
endinterface

// File: rtl/ram_cmd_sequencer.sv
// Turns WRITE / READ / WRITE_READ burst commands into dual-port RAM strobes and
// returns read data, with per-beat readback checking, on a response channel.
module ram_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input logic                clk,
  input logic                rst_n,
  ram_cmd_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StCapture, StResp, StDone} state_e;

  localparam logic [1:0] OpWrite   = 2'd0;
  localparam logic [1:0] OpRead    = 2'd1;
  localparam logic [1:0] OpWrRd    = 2'd2;
  localparam logic [1:0] OpIllegal = 2'd3;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  err_acc_q, err_acc_d;

  logic                  wr_enbl_q, wr_enbl_d;
  logic                  rd_enbl_q, rd_enbl_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  done_err_q, done_err_d;

  logic                  last_beat;
  logic [LEN_WIDTH-1:0]  nxt_beat;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  mismatch;

  assign last_beat = (beat_q == len_q);
  assign nxt_beat  = beat_q + LEN_WIDTH'(1);
  assign nxt_addr  = addr_q + ADDR_WIDTH'(1);
  assign cur_data  = seed_q + DATA_WIDTH'(beat_q);
  assign nxt_data  = seed_q + DATA_WIDTH'(nxt_beat);
  assign mismatch  = (op_q == OpWrRd) && (bus.rd_data != cur_data);

  // Strobe and response registers are loaded with the values that belong to
  // the state being entered, so every output is a flop and none sees an input.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    len_d       = len_q;
    beat_d      = beat_q;
    err_acc_d   = err_acc_q;
    wr_enbl_d   = 1'b0;
    rd_enbl_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_data_d   = wr_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    cmd_done_d  = 1'b0;
    done_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          addr_d    = bus.cmd_addr;
          seed_d    = bus.cmd_data;
          len_d     = bus.cmd_len;
          beat_d    = '0;
          err_acc_d = 1'b0;
          unique case (bus.cmd_op)
            OpWrite, OpWrRd: begin
              state_d   = StWrite;
              wr_enbl_d = 1'b1;
              wr_addr_d = bus.cmd_addr;
              wr_data_d = bus.cmd_data;
            end
            OpRead: begin
              state_d   = StRead;
              rd_enbl_d = 1'b1;
              rd_addr_d = bus.cmd_addr;
            end
            OpIllegal: begin
              state_d    = StDone;
              cmd_done_d = 1'b1;
              done_err_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        if (op_q == OpWrRd) begin
          state_d   = StRead;
          rd_enbl_d = 1'b1;
          rd_addr_d = addr_q;
        end else if (!last_beat) begin
          beat_d    = nxt_beat;
          addr_d    = nxt_addr;
          wr_enbl_d = 1'b1;
          wr_addr_d = nxt_addr;
          wr_data_d = nxt_data;
        end else begin
          state_d    = StDone;
          cmd_done_d = 1'b1;
          done_err_d = err_acc_q;
        end
      end
      StRead: begin
        state_d = StCapture;
      end
      StCapture: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.rd_data;
        rsp_addr_d  = addr_q;
        rsp_err_d   = mismatch;
        err_acc_d   = err_acc_q | mismatch;
      end
      StResp: begin
        if (!bus.rsp_ready) begin
          rsp_valid_d = 1'b1;
        end else if (!last_beat) begin
          beat_d = nxt_beat;
          addr_d = nxt_addr;
          if (op_q == OpWrRd) begin
            state_d   = StWrite;
            wr_enbl_d = 1'b1;
            wr_addr_d = nxt_addr;
            wr_data_d = nxt_data;
          end else begin
            state_d   = StRead;
            rd_enbl_d = 1'b1;
            rd_addr_d = nxt_addr;
          end
        end else begin
          state_d    = StDone;
          cmd_done_d = 1'b1;
          done_err_d = err_acc_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      addr_q      <= '0;
      seed_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      err_acc_q   <= 1'b0;
      wr_enbl_q   <= 1'b0;
      rd_enbl_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
      cmd_done_q  <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      err_acc_q   <= err_acc_d;
      wr_enbl_q   <= wr_enbl_d;
      rd_enbl_q   <= rd_enbl_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
      cmd_done_q  <= cmd_done_d;
      done_err_q  <= done_err_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.wr_enbl   = wr_enbl_q;
  assign bus.rd_enbl   = rd_enbl_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.cmd_done  = cmd_done_q;
  assign bus.done_err  = done_err_q;

endmodule

// File: tb/tb_ram_cmd_sequencer.sv
// Directed bench for ram_cmd_sequencer: command table plus hand-written
// backpressure and mid-burst reset sequences, against a small RAM model.
module tb_ram_cmd_sequencer;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_cmd_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ram_cmd_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // RAM model: registered read, optional corruption of address 2 on readback.
  logic [7:0] mem [16];
  bit         corrupt;
  always @(posedge clk) begin
    if (bus.wr_enbl) mem[bus.wr_addr] <= bus.wr_data;
    if (bus.rd_enbl)
      bus.rd_data <= mem[bus.rd_addr] ^ ((corrupt && bus.rd_addr == 4'd2) ? 8'h5A : 8'h00);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [3:0] a;
    logic [7:0] d;
    logic       e;
  } ev_t;

  ev_t wr_log[$];
  ev_t rd_log[$];
  ev_t rsp_log[$];
  ev_t done_log[$];
  int  overlap = 0;

  always @(negedge clk) begin
    if (bus.wr_enbl) wr_log.push_back('{t: cyc, a: bus.wr_addr, d: bus.wr_data, e: 1'b0});
    if (bus.rd_enbl) rd_log.push_back('{t: cyc, a: bus.rd_addr, d: 8'h00, e: 1'b0});
    if (bus.rsp_valid && bus.rsp_ready)
      rsp_log.push_back('{t: cyc, a: bus.rsp_addr, d: bus.rsp_data, e: bus.rsp_err});
    if (bus.cmd_done) done_log.push_back('{t: cyc, a: 4'h0, d: 8'h00, e: bus.done_err});
    if (bus.wr_enbl && bus.rd_enbl) overlap++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [33:0] all_outs();
    return {bus.wr_enbl, bus.rd_enbl, bus.wr_addr, bus.rd_addr, bus.wr_data, bus.rsp_valid,
            bus.rsp_data, bus.rsp_addr, bus.rsp_err, bus.cmd_done, bus.done_err};
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [3:0]  len;
    bit          corrupt;
    int          lat;
    bit          derr;
    int          nwr;
    int          nrd;
    int          nrsp;
    logic [7:0]  rd0;
    logic [15:0] err_mask;
    int          wr_t0;
    int          wr_per;
    int          rsp_t0;
    int          rsp_per;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int          wb, rb, sb, db, c, n;
    logic [7:0]  exp_d;
    wb = wr_log.size();
    rb = rd_log.size();
    sb = rsp_log.size();
    db = done_log.size();
    corrupt       = v.corrupt;
    bus.rsp_ready = 1'b1;
    chk($sformatf("v%0d cmd_ready before", idx), bus.cmd_ready, 1);
    c = cyc;
    bus.cmd_op    = v.op;
    bus.cmd_addr  = v.addr;
    bus.cmd_data  = v.data;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (done_log.size() == db && n < 200) begin
      tick();
      n++;
    end
    if (done_log.size() == db) begin
      chk($sformatf("v%0d cmd_done timeout", idx), 0, 1);
    end else begin
      chk($sformatf("v%0d done latency", idx), done_log[db].t - c, v.lat);
      chk($sformatf("v%0d done_err", idx), done_log[db].e, v.derr);
    end
    tick();
    chk($sformatf("v%0d cmd_done one cycle", idx), bus.cmd_done, 0);
    chk($sformatf("v%0d cmd_ready after", idx), bus.cmd_ready, 1);
    chk($sformatf("v%0d write count", idx), wr_log.size() - wb, v.nwr);
    chk($sformatf("v%0d read count", idx), rd_log.size() - rb, v.nrd);
    chk($sformatf("v%0d rsp count", idx), rsp_log.size() - sb, v.nrsp);
    for (int k = 0; k < v.nwr; k++) begin
      if (wb + k < wr_log.size()) begin
        chk($sformatf("v%0d wr%0d addr", idx, k), wr_log[wb+k].a, 4'(v.addr + 4'(k)));
        chk($sformatf("v%0d wr%0d data", idx, k), wr_log[wb+k].d, 8'(v.data + 8'(k)));
        chk($sformatf("v%0d wr%0d time", idx, k), wr_log[wb+k].t - c, v.wr_t0 + k * v.wr_per);
      end
    end
    for (int k = 0; k < v.nrd; k++) begin
      if (rb + k < rd_log.size())
        chk($sformatf("v%0d rd%0d addr", idx, k), rd_log[rb+k].a, 4'(v.addr + 4'(k)));
    end
    for (int k = 0; k < v.nrsp; k++) begin
      if (sb + k < rsp_log.size()) begin
        exp_d = 8'(v.rd0 + 8'(k)) ^ (v.err_mask[k] ? 8'h5A : 8'h00);
        chk($sformatf("v%0d rsp%0d addr", idx, k), rsp_log[sb+k].a, 4'(v.addr + 4'(k)));
        chk($sformatf("v%0d rsp%0d data", idx, k), rsp_log[sb+k].d, exp_d);
        chk($sformatf("v%0d rsp%0d err", idx, k), rsp_log[sb+k].e, v.err_mask[k]);
        chk($sformatf("v%0d rsp%0d time", idx, k), rsp_log[sb+k].t - c, v.rsp_t0 + k * v.rsp_per);
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int db;
    //          op     addr   data   len  cor lat derr nwr nrd nrsp rd0    mask  wt0 wp rt0 rp
    vecs[0] = '{2'd0, 4'd3,  8'h10, 4'd2, 0, 4,  0,   3,  0,  0,  8'h00, 16'h0, 1, 1, 0, 0};
    vecs[1] = '{2'd1, 4'd3,  8'h00, 4'd2, 0, 10, 0,   0,  3,  3,  8'h10, 16'h0, 0, 0, 3, 3};
    vecs[2] = '{2'd2, 4'd14, 8'hFE, 4'd3, 0, 17, 0,   4,  4,  4,  8'hFE, 16'h0, 1, 4, 4, 4};
    vecs[3] = '{2'd2, 4'd0,  8'h40, 4'd3, 1, 17, 1,   4,  4,  4,  8'h40, 16'h4, 1, 4, 4, 4};
    vecs[4] = '{2'd3, 4'd5,  8'h99, 4'd2, 0, 1,  1,   0,  0,  0,  8'h00, 16'h0, 0, 0, 0, 0};
    vecs[5] = '{2'd1, 4'd14, 8'h00, 4'd1, 0, 7,  0,   0,  2,  2,  8'hFE, 16'h0, 0, 0, 3, 3};
    vecs[6] = '{2'd0, 4'd15, 8'h77, 4'd0, 0, 2,  0,   1,  0,  0,  8'h00, 16'h0, 1, 1, 0, 0};
    vecs[7] = '{2'd1, 4'd15, 8'h00, 4'd0, 0, 4,  0,   0,  1,  1,  8'h77, 16'h0, 0, 0, 3, 3};

    rst_n         = 1'b0;
    corrupt       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_addr  = 4'd0;
    bus.cmd_data  = 8'd0;
    bus.cmd_len   = 4'd0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    chk("reset outputs zero", all_outs(), 0);
    chk("reset cmd_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure: READ addr 4 len 1, consumer stalls the first response.
    bus.rsp_ready = 1'b0;
    bus.cmd_op    = 2'd1;
    bus.cmd_addr  = 4'd4;
    bus.cmd_len   = 4'd1;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp rsp_valid seen", bus.rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp stall%0d rsp_valid", k), bus.rsp_valid, 1);
      chk($sformatf("bp stall%0d rsp_data", k), bus.rsp_data, 8'h11);
      chk($sformatf("bp stall%0d rsp_addr", k), bus.rsp_addr, 4'd4);
      chk($sformatf("bp stall%0d no strobe", k), {bus.rd_enbl, bus.wr_enbl}, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp resume rd_enbl", bus.rd_enbl, 1);
    chk("bp resume rd_addr", bus.rd_addr, 4'd5);
    chk("bp resume rsp_valid low", bus.rsp_valid, 0);
    tick();
    tick();
    chk("bp beat1 rsp_valid", bus.rsp_valid, 1);
    chk("bp beat1 rsp_data", bus.rsp_data, 8'h12);
    chk("bp beat1 rsp_addr", bus.rsp_addr, 4'd5);
    tick();
    chk("bp cmd_done", bus.cmd_done, 1);
    chk("bp done_err", bus.done_err, 0);
    tick();
    chk("bp cmd_ready", bus.cmd_ready, 1);

    // Reset in the middle of a READ burst: outputs drop without a clock edge.
    db            = done_log.size();
    bus.cmd_op    = 2'd1;
    bus.cmd_addr  = 4'd14;
    bus.cmd_len   = 4'd3;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!(bus.rd_enbl && bus.rd_addr == 4'd15) && n < 20) begin
      tick();
      n++;
    end
    chk("rst second-beat rd_enbl", bus.rd_enbl, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst async outputs zero", all_outs(), 0);
    chk("rst async cmd_ready", bus.cmd_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("rst no cmd_done", done_log.size() - db, 0);
    chk("rst idle outputs zero", all_outs(), 0);
    chk("rst cmd_ready after release", bus.cmd_ready, 1);

    chk("strobe overlap count", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
